// File: rtl/ara_th_pkg.sv
// Shared widths, memory map and types for the Ara test harness.
package ara_th_pkg;

    localparam int unsigned DefNrLanes      = 4;
    localparam int unsigned DefNrClusters   = 1;
    localparam int unsigned DefAxiAddrWidth = 64;
    localparam int unsigned DefAxiDataWidth = 32 * DefNrLanes * DefNrClusters;

    typedef logic [DefAxiAddrWidth-1:0] addr_t;
    typedef logic [DefAxiDataWidth-1:0] data_t;

    localparam addr_t DRAMAddrBase = 64'h8000_0000;
    localparam addr_t DRAMLength   = 64'h4000_0000;

endpackage

// File: rtl/ara_th_if.sv
// Status bundle from the SoC into the harness: tohost exit word, the
// hardware-counter enable and the CVA6 events that feed the counters.
interface ara_th_if;

    logic [63:0] exit_word;
    logic [0:0]  hw_cnt_en;
    logic        dcache_stall;
    logic        icache_stall;
    logic        sb_full;

    modport soc     (output exit_word, hw_cnt_en, dcache_stall, icache_stall, sb_full);
    modport harness (input  exit_word, hw_cnt_en, dcache_stall, icache_stall, sb_full);

endinterface

// File: rtl/ara_soc.sv
// Behavioural SoC model for harness builds without the full Ara sources.
// It runs a fixed program profile: counters enabled for cycles [10,50),
// synthetic cache/scoreboard events inside that window, then a passing
// tohost write once the response delay has elapsed.
module ara_soc #(
    parameter int unsigned AxiRespDelay = 200
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    ara_th_if.soc    status
);

    // tohost lands a little after the loop; AxiRespDelay is in ps.
    localparam logic [7:0] ExitCycle = 8'(60 + AxiRespDelay / 100);

    logic [7:0]  cyc_q;
    logic [63:0] exit_o;
    logic [0:0]  hw_cnt_en_o;

    // Free-running program cycle count, saturating once the program ends.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)              cyc_q <= '0;
        else if (cyc_q != 8'hff)  cyc_q <= cyc_q + 8'd1;
    end

    assign hw_cnt_en_o         = (cyc_q >= 8'd10 && cyc_q < 8'd50) ? 1'b1 : 1'b0;
    assign exit_o              = (cyc_q >= ExitCycle) ? 64'h1 : 64'h0;
    assign status.exit_word    = exit_o;
    assign status.hw_cnt_en    = hw_cnt_en_o;
    assign status.dcache_stall = hw_cnt_en_o[0] && (cyc_q[2:0] == 3'd0);
    assign status.icache_stall = hw_cnt_en_o[0] && (cyc_q[3:0] == 4'd1);
    assign status.sb_full      = hw_cnt_en_o[0] && (cyc_q[4:0] == 5'd20);

endmodule

// File: rtl/ara_th_perf_cnt.sv
// One 64-bit gated event counter. A rising enable restarts the count, a
// falling enable copies the count into the result buffer.
module ara_th_perf_cnt (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        event_i,
    output logic [63:0] buf_o
);

    logic        en_q;
    logic [63:0] cnt_q;
    logic [63:0] buf_q;

    // Enable edge detection drives restart / accumulate / publish.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q  <= 1'b0;
            cnt_q <= '0;
            buf_q <= '0;
        end else begin
            en_q <= en_i;
            unique case ({en_i, en_q})
                2'b10:   cnt_q <= {63'd0, event_i};
                2'b11:   cnt_q <= cnt_q + {63'd0, event_i};
                2'b01:   buf_q <= cnt_q;
                default: ;
            endcase
        end
    end

    assign buf_o = buf_q;

endmodule

// File: rtl/ara_test_harness.sv
// Simulation top: wraps the SoC, adapts reset, latches the first exit
// word and collects four gated performance counters.
module ara_test_harness
    import ara_th_pkg::*;
#(
    parameter int unsigned NrLanes             = DefNrLanes,
    parameter int unsigned NrClusters          = DefNrClusters,
    parameter int unsigned AxiAddrWidth        = DefAxiAddrWidth,
    parameter int unsigned ClusterAxiDataWidth = 32 * NrLanes,
    parameter int unsigned AxiDataWidth        = 32 * NrLanes * NrClusters,
    parameter int unsigned AxiRespDelay        = 200
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [63:0] exit_o
);

    if (ClusterAxiDataWidth != 32 * NrLanes) begin : g_chk_cw
        $fatal(1, "ClusterAxiDataWidth must equal 32*NrLanes");
    end
    if (AxiDataWidth != ClusterAxiDataWidth * NrClusters) begin : g_chk_dw
        $fatal(1, "AxiDataWidth must equal ClusterAxiDataWidth*NrClusters");
    end
    if (NrLanes < 2 || NrLanes > 16 || (NrLanes & (NrLanes - 1)) != 0) begin : g_chk_lanes
        $fatal(1, "NrLanes must be a power of two in 2..16");
    end
    if (NrClusters < 1) begin : g_chk_cl
        $fatal(1, "NrClusters must be at least 1");
    end
    if (AxiAddrWidth < 32) begin : g_chk_aw
        $fatal(1, "AxiAddrWidth too narrow for the DRAM map");
    end

    ara_th_if soc_if ();

    ara_soc #(
        .AxiRespDelay (AxiRespDelay)
    ) i_ara_soc (
        .clk_i  (clk_i),
        .rst_ni (~rst_i),
        .status (soc_if.soc)
    );

    logic [63:0] exit_q;
    logic [63:0] runtime_buf_q;
    logic [63:0] dcache_stall_buf_q;
    logic [63:0] icache_stall_buf_q;
    logic [63:0] sb_full_buf_q;
    logic        en;

    assign en = soc_if.hw_cnt_en[0];

    // First exit word with bit 0 set is kept until reset.
    always_ff @(posedge clk_i) begin
        if (rst_i)                                   exit_q <= '0;
        else if (!exit_q[0] && soc_if.exit_word[0])  exit_q <= soc_if.exit_word;
    end

    assign exit_o = exit_q;

    ara_th_perf_cnt i_runtime_cnt (
        .clk_i (clk_i), .rst_i (rst_i), .en_i (en),
        .event_i (1'b1), .buf_o (runtime_buf_q)
    );
    ara_th_perf_cnt i_dcache_cnt (
        .clk_i (clk_i), .rst_i (rst_i), .en_i (en),
        .event_i (soc_if.dcache_stall), .buf_o (dcache_stall_buf_q)
    );
    ara_th_perf_cnt i_icache_cnt (
        .clk_i (clk_i), .rst_i (rst_i), .en_i (en),
        .event_i (soc_if.icache_stall), .buf_o (icache_stall_buf_q)
    );
    ara_th_perf_cnt i_sb_full_cnt (
        .clk_i (clk_i), .rst_i (rst_i), .en_i (en),
        .event_i (soc_if.sb_full), .buf_o (sb_full_buf_q)
    );

endmodule

// File: tb/tb_ara_test_harness.sv
// Directed bench: standalone gated counter, then the harness exit latch
// and the counters fed by the SoC program profile.
module tb_ara_test_harness;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_rst;
    logic [63:0] exit_o;
    logic [63:0] c_buf;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    ara_th_if tb_if ();

    ara_test_harness dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .exit_o (exit_o)
    );

    ara_th_perf_cnt u_cnt (
        .clk_i   (clk),
        .rst_i   (c_rst),
        .en_i    (tb_if.hw_cnt_en[0]),
        .event_i (tb_if.dcache_stall),
        .buf_o   (c_buf)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        c_rst = 1'b1;
        tb_if.hw_cnt_en = 1'b0;
        tb_if.dcache_stall = 1'b0;
        tick(5);
        chk("rst_exit", exit_o, 64'h0);
        chk("rst_runtime", dut.runtime_buf_q, 64'h0);
        chk("rst_dcache", dut.dcache_stall_buf_q, 64'h0);
        chk("rst_icache", dut.icache_stall_buf_q, 64'h0);
        chk("rst_sbfull", dut.sb_full_buf_q, 64'h0);
        chk("rst_cbuf", c_buf, 64'h0);

        // Standalone counter: 100-cycle window with an event every cycle.
        c_rst = 1'b0;
        tick(2);
        tb_if.hw_cnt_en = 1'b1;
        tb_if.dcache_stall = 1'b1;
        tick(100);
        tb_if.hw_cnt_en = 1'b0;
        tb_if.dcache_stall = 1'b0;
        tick(1);
        chk("cnt_runtime", c_buf, 64'd100);
        tick(20);
        chk("cnt_runtime_hold", c_buf, 64'd100);

        // Alternate-cycle events over 10 cycles, then a fresh 3-cycle window.
        tb_if.hw_cnt_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tb_if.dcache_stall = (i % 2 == 0);
            tick(1);
        end
        tb_if.hw_cnt_en = 1'b0;
        tb_if.dcache_stall = 1'b0;
        tick(1);
        chk("cnt_sparse", c_buf, 64'd5);
        tick(3);
        tb_if.hw_cnt_en = 1'b1;
        tb_if.dcache_stall = 1'b1;
        tick(3);
        tb_if.hw_cnt_en = 1'b0;
        tb_if.dcache_stall = 1'b0;
        tick(1);
        chk("cnt_second_window", c_buf, 64'd3);

        // Reset 50 cycles into a window, then a 20-cycle window.
        tb_if.hw_cnt_en = 1'b1;
        tb_if.dcache_stall = 1'b1;
        tick(50);
        c_rst = 1'b1;
        tb_if.hw_cnt_en = 1'b0;
        tick(1);
        chk("cnt_midrst_cnt", u_cnt.cnt_q, 64'h0);
        chk("cnt_midrst_buf", c_buf, 64'h0);
        c_rst = 1'b0;
        tick(2);
        tb_if.hw_cnt_en = 1'b1;
        tick(20);
        tb_if.hw_cnt_en = 1'b0;
        tick(1);
        chk("cnt_after_rst", c_buf, 64'd20);

        // Harness exit: first word 7 (tohost=3) sticks over a later 1.
        rst = 1'b0;
        tick(5);
        chk("exit_idle", exit_o, 64'h0);
        force dut.i_ara_soc.exit_o = 64'h7;
        tick(1);
        chk("exit_first7", exit_o, 64'h7);
        chk("exit_tohost", {1'b0, exit_o[63:1]}, 64'd3);
        force dut.i_ara_soc.exit_o = 64'h1;
        tick(3);
        chk("exit_sticky7", exit_o, 64'h7);
        release dut.i_ara_soc.exit_o;

        // Exit 1 first, later 7 ignored.
        rst = 1'b1;
        tick(2);
        chk("exit_reset", exit_o, 64'h0);
        rst = 1'b0;
        force dut.i_ara_soc.exit_o = 64'h1;
        tick(1);
        chk("exit_first1", exit_o, 64'h1);
        force dut.i_ara_soc.exit_o = 64'h7;
        tick(2);
        chk("exit_sticky1", exit_o, 64'h1);
        release dut.i_ara_soc.exit_o;

        // Full program profile: window of 40 cycles, passing tohost.
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        for (int i = 0; i < 300 && !exit_o[0]; i++) tick(1);
        chk("sys_exit_seen", {63'd0, exit_o[0]}, 64'h1);
        chk("sys_exit_code", {1'b0, exit_o[63:1]}, 64'h0);
        chk("sys_runtime", dut.runtime_buf_q, 64'd40);
        chk("sys_dcache", dut.dcache_stall_buf_q, 64'd5);
        chk("sys_icache", dut.icache_stall_buf_q, 64'd3);
        chk("sys_sbfull", dut.sb_full_buf_q, 64'd1);
        tick(10);
        chk("sys_runtime_hold", dut.runtime_buf_q, 64'd40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
